// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates the shared 16-bit address / 8-bit data memory
// bus between the CPU (port 0) and the DMA/program-loader (port 1).
// Decodes ROM versus RAM, inserts ROM wait states, traps writes to ROM and
// times out RAM accesses whose mem_ready never arrives. All outputs are
// registered. The per-requester response registers sit in a small sub-module
// that is instantiated once per port.

// Response register for one requester: one-cycle ack, error and read data.
module mem_bus_arbiter_port (
    input  logic       clk,
    input  logic       reset,
    input  logic       rsp_vld,
    input  logic       rsp_err,
    input  logic       rsp_upd,
    input  logic [7:0] rsp_data,
    output logic       ack,
    output logic       err,
    output logic [7:0] rdata
);

    // ack/err pulse with the response; rdata only moves when data is returned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= 8'h00;
        end else begin
            ack <= rsp_vld;
            err <= rsp_vld & rsp_err;
            if (rsp_vld && rsp_upd)
                rdata <= rsp_data;
        end
    end

endmodule

module mem_bus_arbiter #(
    parameter logic [15:0] ROM_TOP     = 16'h0100,
    parameter int          ROM_WAIT    = 0,
    parameter int          RAM_TIMEOUT = 15,
    parameter int          RR_MODE     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        dma_err,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Last ACCESS-cycle counter values for the ROM and RAM exits.
    localparam logic [7:0] ROM_LAST = 8'(ROM_WAIT);
    localparam logic [7:0] TO_LAST  = 8'(RAM_TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       rr_pref;     // port preferred on a tie in round-robin mode

    // Arbitration / request selection
    logic        cpu_win;
    logic        gnt_port;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        sel_rom;
    logic        rom_trap;

    // ACCESS completion
    logic acc_rom;
    logic rom_done;
    logic ram_ok;
    logic ram_to;
    logic acc_done;

    // Response towards the port registers
    logic            rsp_go;
    logic            rsp_port;
    logic            rsp_err;
    logic            rsp_upd;
    logic [7:0]      rsp_data;
    logic [1:0]      rsp_vld;
    logic [1:0]      ack_q;
    logic [1:0]      err_q;
    logic [1:0][7:0] rdata_q;

    // Pick the winner among pending requests and mux its request fields.
    always_comb begin
        cpu_win = 1'b0;
        if (RR_MODE == 0)
            cpu_win = cpu_req;
        else
            cpu_win = cpu_req && (!dma_req || (rr_pref == 1'b0));
        gnt_port  = !cpu_win;
        sel_we    = cpu_win ? cpu_we    : dma_we;
        sel_addr  = cpu_win ? cpu_addr  : dma_addr;
        sel_wdata = cpu_win ? cpu_wdata : dma_wdata;
        sel_rom   = sel_addr < ROM_TOP;
        rom_trap  = (cpu_req || dma_req) && sel_we && sel_rom;
    end

    // Decide whether the current ACCESS cycle is the last one.
    always_comb begin
        acc_rom  = mem_addr < ROM_TOP;
        rom_done = acc_rom && (wait_cnt >= ROM_LAST);
        ram_ok   = !acc_rom && mem_ready;
        ram_to   = !acc_rom && !mem_ready && (wait_cnt >= TO_LAST);
        acc_done = rom_done || ram_ok || ram_to;
    end

    // Build the response loaded into the owner's port register this edge.
    always_comb begin
        rsp_go   = 1'b0;
        rsp_port = owner;
        rsp_err  = 1'b0;
        rsp_upd  = 1'b0;
        rsp_data = ram_to ? 8'hFF : mem_rdata;
        if (state == IDLE) begin
            // Trapped ROM write: error, read data left untouched.
            rsp_go   = rom_trap;
            rsp_port = gnt_port;
            rsp_err  = 1'b1;
        end else if (state == ACCESS) begin
            rsp_go  = acc_done;
            rsp_err = ram_to;
            rsp_upd = ram_to || !mem_write;
        end
        rsp_vld[0] = rsp_go && (rsp_port == 1'b0);
        rsp_vld[1] = rsp_go && (rsp_port == 1'b1);
    end

    // Main FSM: grant, drive the bus, wait/timeout, then one response cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 8'h00;
            rr_pref   <= 1'b0;
            owner     <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        owner <= gnt_port;
                        busy  <= 1'b1;
                        if (rom_trap) begin
                            // ROM write never reaches the bus.
                            state <= RESP;
                        end else begin
                            state     <= ACCESS;
                            wait_cnt  <= 8'h00;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_we ? sel_wdata : 8'h00;
                            mem_read  <= !sel_we;
                            mem_write <= sel_we;
                        end
                    end
                end
                ACCESS: begin
                    if (acc_done) begin
                        state     <= RESP;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (RR_MODE != 0)
                        rr_pref <= !owner;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One response register per requester.
    for (genvar p = 0; p < 2; p++) begin : g_port
        mem_bus_arbiter_port u_port (
            .clk      (clk),
            .reset    (reset),
            .rsp_vld  (rsp_vld[p]),
            .rsp_err  (rsp_err),
            .rsp_upd  (rsp_upd),
            .rsp_data (rsp_data),
            .ack      (ack_q[p]),
            .err      (err_q[p]),
            .rdata    (rdata_q[p])
        );
    end

    assign cpu_ack   = ack_q[0];
    assign cpu_err   = err_q[0];
    assign cpu_rdata = rdata_q[0];
    assign dma_ack   = ack_q[1];
    assign dma_err   = err_q[1];
    assign dma_rdata = rdata_q[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (fixed priority / ROM_WAIT=0 /
// timeout 15, and round-robin / ROM_WAIT=2 / timeout 5) driven through
// directed and random transaction lists. A transaction-level model predicts
// grant order, ack cycle, err and rdata for every access.
module tb_mem_bus_arbiter;

    localparam logic [15:0] ROM_TOP = 16'h0100;

    function automatic int romw(input int i); return (i == 0) ? 0 : 2; endfunction
    function automatic int tout(input int i); return (i == 0) ? 15 : 5; endfunction
    function automatic int rrm(input int i);  return (i == 0) ? 0 : 1; endfunction

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    typedef struct {
        int         port;
        int         cyc;
        logic       err;
        logic [7:0] rdata;
        logic       chkrd;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;

    logic        cpu_req [2], cpu_we [2], cpu_ack [2], cpu_err [2];
    logic [15:0] cpu_addr [2];
    logic [7:0]  cpu_wdata [2], cpu_rdata [2];
    logic        dma_req [2], dma_we [2], dma_ack [2], dma_err [2];
    logic [15:0] dma_addr [2];
    logic [7:0]  dma_wdata [2], dma_rdata [2];
    logic [15:0] mem_addr [2];
    logic [7:0]  mem_wdata [2], mem_rdata [2];
    logic        mem_read [2], mem_write [2], mem_ready [2], owner [2], busy [2];

    logic [7:0] env_mem [2][65536];   // the ROM/RAM devices on the bus
    logic [7:0] ref_mem [2][65536];   // model's view of memory
    int         rdly [2];             // RAM ready delay in ACCESS cycles
    int         last_g [2];           // model: port granted last

    txn_t cq [$];
    txn_t dq [$];
    rsp_t exp_q [$];
    int   exp_strb;
    int   exp_last;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        int rcnt = 0;

        mem_bus_arbiter #(
            .ROM_TOP     (ROM_TOP),
            .ROM_WAIT    (g == 0 ? 0 : 2),
            .RAM_TIMEOUT (g == 0 ? 15 : 5),
            .RR_MODE     (g == 0 ? 0 : 1)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_ack   (cpu_ack[g]),
            .cpu_rdata (cpu_rdata[g]),
            .cpu_err   (cpu_err[g]),
            .dma_req   (dma_req[g]),
            .dma_we    (dma_we[g]),
            .dma_addr  (dma_addr[g]),
            .dma_wdata (dma_wdata[g]),
            .dma_ack   (dma_ack[g]),
            .dma_rdata (dma_rdata[g]),
            .dma_err   (dma_err[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_read  (mem_read[g]),
            .mem_write (mem_write[g]),
            .mem_rdata (mem_rdata[g]),
            .mem_ready (mem_ready[g]),
            .owner     (owner[g]),
            .busy      (busy[g])
        );

        // RAM device: ready after rdly strobe cycles, write commits on ready.
        always @(posedge clk) rcnt <= (mem_read[g] | mem_write[g]) ? rcnt + 1 : 0;
        assign mem_ready[g] = (mem_read[g] | mem_write[g]) && (rcnt >= rdly[g]);
        assign mem_rdata[g] = env_mem[g][mem_addr[g]];
    end

    always @(posedge clk)
        for (int k = 0; k < 2; k++)
            if (mem_write[k] && mem_ready[k])
                env_mem[k][mem_addr[k]] = mem_wdata[k];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs(input int i);
        return {16'h0, cpu_ack[i], dma_ack[i], cpu_err[i], dma_err[i], mem_read[i],
                mem_write[i], busy[i], owner[i], mem_addr[i], mem_wdata[i],
                cpu_rdata[i], dma_rdata[i]};
    endfunction

    function automatic txn_t mk(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    function automatic txn_t rnd_tx();
        int s;
        logic [15:0] a;
        s = $urandom_range(0, 3);
        case (s)
            0:       a = 16'($urandom_range(0, 255));
            1:       a = 16'(ROM_TOP - 16'd1);
            2:       a = ROM_TOP;
            default: a = 16'(ROM_TOP + 16'($urandom_range(0, 7)));
        endcase
        return mk(1'($urandom_range(0, 1)), a, 8'($urandom));
    endfunction

    task automatic setmem(input int i, input logic [15:0] a, input logic [7:0] v);
        env_mem[i][a] = v;
        ref_mem[i][a] = v;
    endtask

    // Transaction-level model: grant order, ack cycle, err and rdata.
    task automatic predict(input int i, input int d);
        txn_t q0 [$];
        txn_t q1 [$];
        txn_t tx;
        rsp_t r;
        int   t, p, acc, lat;
        q0 = cq; q1 = dq;
        t = 0; exp_strb = 0; exp_last = 0;
        exp_q.delete();
        while (q0.size() > 0 || q1.size() > 0) begin
            if (q0.size() > 0 && q1.size() > 0) p = (rrm(i) == 0) ? 0 : 1 - last_g[i];
            else p = (q0.size() > 0) ? 0 : 1;
            tx = (p == 0) ? q0.pop_front() : q1.pop_front();
            last_g[i] = p;
            r.port = p; r.rdata = 8'h00; r.chkrd = 1'b0; r.err = 1'b0;
            if (tx.addr < ROM_TOP && tx.we) begin
                acc = 0; lat = 1; r.err = 1'b1;
            end else if (tx.addr < ROM_TOP) begin
                acc = romw(i) + 1; lat = acc + 1;
                r.rdata = ref_mem[i][tx.addr]; r.chkrd = 1'b1;
            end else if (d + 1 <= tout(i)) begin
                acc = d + 1; lat = acc + 1;
                r.rdata = ref_mem[i][tx.addr]; r.chkrd = !tx.we;
                if (tx.we) ref_mem[i][tx.addr] = tx.wdata;
            end else begin
                acc = tout(i); lat = acc + 1;
                r.err = 1'b1; r.rdata = 8'hFF; r.chkrd = 1'b1;
            end
            t += lat;
            r.cyc = t;
            exp_q.push_back(r);
            exp_strb += acc;
            exp_last = t;
            t += 1;
        end
    endtask

    task automatic drive(input int i, input int p, input txn_t tx);
        if (p == 0) begin
            cpu_req[i] = 1'b1; cpu_we[i] = tx.we; cpu_addr[i] = tx.addr; cpu_wdata[i] = tx.wdata;
        end else begin
            dma_req[i] = 1'b1; dma_we[i] = tx.we; dma_addr[i] = tx.addr; dma_wdata[i] = tx.wdata;
        end
    endtask

    task automatic take(input int i, input int p, input int cyc);
        rsp_t e;
        txn_t tmp;
        chk("ack_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("ack_port", p, e.port);
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_err", (p == 0) ? cpu_err[i] : dma_err[i], e.err);
        if (e.chkrd) chk("ack_rdata", (p == 0) ? cpu_rdata[i] : dma_rdata[i], e.rdata);
        if (p == 0) begin
            if (cq.size() > 0) tmp = cq.pop_front();
            if (cq.size() > 0) drive(i, 0, cq[0]); else cpu_req[i] = 1'b0;
        end else begin
            if (dq.size() > 0) tmp = dq.pop_front();
            if (dq.size() > 0) drive(i, 1, dq[0]); else dma_req[i] = 1'b0;
        end
    endtask

    // Present both queues at once, follow acks, then check the bus activity.
    task automatic run(input int i, input int d);
        int cyc, budget, strb;
        rdly[i] = d;
        predict(i, d);
        budget = exp_last + 10;
        @(posedge clk); #1;
        if (cq.size() > 0) drive(i, 0, cq[0]);
        if (dq.size() > 0) drive(i, 1, dq[0]);
        cyc = 0; strb = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_read[i] | mem_write[i]) strb++;
            if (mem_write[i]) chk("wr_region", mem_addr[i] >= ROM_TOP, 1'b1);
            if (cpu_ack[i]) take(i, 0, cyc);
            if (dma_ack[i]) take(i, 1, cyc);
        end
        chk("acks_outstanding", exp_q.size(), 0);
        chk("strobe_cycles", strb, exp_strb);
        repeat (2) begin
            @(posedge clk); #1;
            chk("no_extra_ack", {cpu_ack[i], dma_ack[i]}, 2'b00);
        end
        cpu_req[i] = 1'b0; dma_req[i] = 1'b0;
        cq.delete(); dq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = 0; cpu_wdata[i] = 0;
            dma_req[i] = 0; dma_we[i] = 0; dma_addr[i] = 0; dma_wdata[i] = 0;
            rdly[i] = 0; last_g[i] = 1;
            for (int a = 0; a < 65536; a++) setmem(i, 16'(a), 8'($urandom));
        end
        setmem(0, 16'h0000, 8'hA9);
        setmem(1, 16'h0000, 8'hA9);
        #1 reset = 1'b0;
        #2;
        chk("reset_outs0", outs(0), 64'h0);
        chk("reset_outs1", outs(1), 64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Fixed-priority instance: directed cases.
        cq.push_back(mk(0, 16'h0000, 8'h00)); run(0, 0);
        dq.push_back(mk(1, 16'h0200, 8'h5F)); run(0, 3);
        cq.push_back(mk(0, 16'h0200, 8'h00)); run(0, 0);
        cq.push_back(mk(1, 16'h00FF, 8'h11)); run(0, 0);
        cq.push_back(mk(1, 16'h0100, 8'h11)); run(0, 0);
        cq.push_back(mk(0, 16'h0100, 8'h00)); run(0, 0);
        for (int k = 0; k < 4; k++) begin
            cq.push_back(mk(0, 16'(16'h0200 + k), 8'h00));
            dq.push_back(mk(0, 16'(16'h0300 + k), 8'h00));
        end
        run(0, 1);
        cq.push_back(mk(0, 16'h1234, 8'h00));
        dq.push_back(mk(0, 16'h0010, 8'h00));
        run(0, 255);

        // Reset in the 2nd ACCESS cycle of a RAM read.
        @(posedge clk); #1;
        rdly[0] = 255;
        drive(0, 0, mk(0, 16'h0300, 8'h00));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_access", {busy[0], mem_read[0]}, 2'b11);
        reset = 1'b0;
        #1;
        chk("midreset_outs0", outs(0), 64'h0);
        chk("midreset_outs1", outs(1), 64'h0);
        cpu_req[0] = 1'b0;
        last_g[0] = 1; last_g[1] = 1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("reset_no_ack", {cpu_ack[0], dma_ack[0], busy[0]}, 3'b000);
        end
        reset = 1'b1;
        cq.push_back(mk(0, 16'h0000, 8'h00)); run(0, 0);

        // Round-robin instance: alternation, ROM wait states, boundary, timeout.
        for (int k = 0; k < 4; k++) begin
            cq.push_back(mk(0, 16'(16'h0400 + k), 8'h00));
            dq.push_back(mk(0, 16'(16'h0500 + k), 8'h00));
        end
        run(1, 0);
        cq.push_back(mk(0, 16'h0000, 8'h00));
        dq.push_back(mk(0, 16'h00FF, 8'h00));
        run(1, 0);
        cq.push_back(mk(1, 16'h0100, 8'h77));
        dq.push_back(mk(1, 16'h00FF, 8'h77));
        run(1, 2);
        dq.push_back(mk(0, 16'h1234, 8'h00));
        cq.push_back(mk(0, 16'h0100, 8'h00));
        run(1, 7);

        // Random transaction lists on both instances.
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 30; r++) begin
                int nc, nd;
                nc = $urandom_range(0, 3);
                nd = $urandom_range(0, 3);
                if (nc == 0 && nd == 0) nc = 1;
                for (int k = 0; k < nc; k++) cq.push_back(rnd_tx());
                for (int k = 0; k < nd; k++) dq.push_back(rnd_tx());
                run(i, $urandom_range(0, tout(i) + 1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
